// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// one op in flight, operands held for the op's latency, ID-tagged response with backpressure.
module alu_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 3,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int OP_W        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b_i,
    input  logic [NUM_REQ*OP_W-1:0]       req_op_i,
    output logic [DATA_WIDTH-1:0]        alu_operand_a_o,
    output logic [DATA_WIDTH-1:0]        alu_operand_b_o,
    output logic [OP_W-1:0]              alu_operation_o,
    input  logic [DATA_WIDTH-1:0]        alu_result_i,
    input  logic                         alu_zero_i,
    input  logic                         alu_negative_i,
    input  logic                         alu_overflow_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic [DATA_WIDTH-1:0]        rsp_result_o,
    output logic                         rsp_zero_o,
    output logic                         rsp_negative_o,
    output logic                         rsp_overflow_o,
    output logic                         busy_o
);
    // state | meaning
    // IDLE  | nothing in flight, accept window open
    // EXEC  | operands held on the ALU, latency counter running
    // RESP  | response registered, waiting for rsp_ready_i
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [OP_W-1:0] ALU_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_MUL = OP_W'(9);

    localparam int              CNT_W    = $clog2(MUL_LATENCY + 1);
    localparam logic [ID_W:0]   NREQ     = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]            state;
    logic [ID_W-1:0]       last_grant;
    logic [ID_W-1:0]       issue_id;
    logic [CNT_W-1:0]      cnt;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W:0]         cand;
    logic                  accept_win;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [OP_W-1:0]       sel_op;

    // Search from last_grant+1 upward, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (ID_W + 1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_ADD;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_idx == ID_W'(r)) begin
                sel_a  = req_operand_a_i[r*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_operand_b_i[r*DATA_WIDTH +: DATA_WIDTH];
                sel_op = req_op_i[r*OP_W +: OP_W];
            end
        end
    end

    // Reset is folded in so no grant is advertised while rst_ni is held low.
    assign accept_win  = rst_ni && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready_i));
    assign accept      = accept_win && grant_found;
    assign req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rsp_valid_o = (state == S_RESP);
    assign busy_o      = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= S_IDLE;
            last_grant      <= LAST_RST;
            issue_id        <= '0;
            cnt             <= '0;
            alu_operand_a_o <= '0;
            alu_operand_b_o <= '0;
            alu_operation_o <= ALU_ADD;
            rsp_id_o        <= '0;
            rsp_result_o    <= '0;
            rsp_zero_o      <= 1'b0;
            rsp_negative_o  <= 1'b0;
            rsp_overflow_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        state          <= S_RESP;
                        rsp_id_o       <= issue_id;
                        rsp_result_o   <= alu_result_i;
                        rsp_zero_o     <= alu_zero_i;
                        rsp_negative_o <= alu_negative_i;
                        rsp_overflow_o <= alu_overflow_i;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state <= accept ? S_EXEC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                last_grant      <= grant_idx;
                issue_id        <= grant_idx;
                alu_operand_a_o <= sel_a;
                alu_operand_b_o <= sel_b;
                alu_operation_o <= sel_op;
                cnt             <= (sel_op == ALU_MUL) ? CNT_W'(MUL_LATENCY - 1) : '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model; the bench also plays the role of the shared ALU.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int ML = 3;
    localparam int IW = 1;
    localparam int OW = 4;

    localparam logic [OW-1:0] OP_ADD = 4'd0;
    localparam logic [OW-1:0] OP_SUB = 4'd1;
    localparam logic [OW-1:0] OP_AND = 4'd2;
    localparam logic [OW-1:0] OP_OR  = 4'd3;
    localparam logic [OW-1:0] OP_XOR = 4'd4;
    localparam logic [OW-1:0] OP_SLL = 4'd5;
    localparam logic [OW-1:0] OP_SRL = 4'd6;
    localparam logic [OW-1:0] OP_SRA = 4'd7;
    localparam logic [OW-1:0] OP_SLT = 4'd8;
    localparam logic [OW-1:0] OP_MUL = 4'd9;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_a;
    logic [NR*DW-1:0]   req_b;
    logic [NR*OW-1:0]   req_op;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [OW-1:0]      alu_op;
    logic [DW-1:0]      alu_res;
    logic               alu_zero;
    logic               alu_neg;
    logic               alu_ovf;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_result;
    logic               rsp_zero;
    logic               rsp_neg;
    logic               rsp_ovf;
    logic               busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MUL_LATENCY(ML), .ID_W(IW), .OP_W(OW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operand_a_i(req_a), .req_operand_b_i(req_b), .req_op_i(req_op),
        .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b), .alu_operation_o(alu_op),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero), .alu_negative_i(alu_neg),
        .alu_overflow_i(alu_ovf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_negative_o(rsp_neg),
        .rsp_overflow_o(rsp_ovf), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return DW'($signed(a) >>> b[4:0]);
            OP_SLT:  return ($signed(a) < $signed(b)) ? DW'(1) : '0;
            OP_MUL:  return a * b;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = ref_alu(op, a, b);
        if (op == OP_ADD) return (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
        if (op == OP_SUB) return (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
        return 1'b0;
    endfunction

    // The shared combinational ALU seen by the arbiter.
    always_comb begin
        alu_res  = ref_alu(alu_op, alu_a, alu_b);
        alu_zero = (alu_res == '0);
        alu_neg  = alu_res[DW-1];
        alu_ovf  = ref_ovf(alu_op, alu_a, alu_b);
    end

    task automatic set_req(input int r, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OW-1:0] op);
        req_valid[r]         = v;
        req_a[r*DW +: DW]    = a;
        req_b[r*DW +: DW]    = b;
        req_op[r*OW +: OW]   = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        set_req(0, 1'b1, 32'd5, 32'd6, OP_ADD);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result got=%0h exp=0", rsp_result); end
        checks++; if ({rsp_zero, rsp_neg, rsp_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {rsp_zero, rsp_neg, rsp_ovf}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu_operands got=%0h/%0h exp=0/0", alu_a, alu_b); end
        checks++; if (alu_op !== OP_ADD) begin errors++; $display("FAIL reset_alu_op got=%0d exp=%0d", alu_op, OP_ADD); end
        set_req(0, 1'b0, 32'd0, 32'd0, OP_ADD);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_post_reset();
        set_req(0, 1'b1, 32'd100, 32'd200, OP_ADD);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        set_req(0, 1'b0, 32'd100, 32'd200, OP_ADD);
        #1;
        checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL post_reset_exec got=%b exp=01", {rsp_valid, busy}); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_result !== 32'd300) begin errors++; $display("FAIL post_reset_result got=%0d exp=300", rsp_result); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL post_reset_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL post_reset_zero got=%b exp=0", rsp_zero); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL post_reset_idle got=%b exp=00", {rsp_valid, busy}); end
        @(negedge clk);
    endtask

    task automatic test_mul();
        set_req(1, 1'b1, 32'd15, 32'd7, OP_MUL);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mul_ready got=%b exp=10", req_ready); end
        @(negedge clk);
        set_req(1, 1'b0, 32'd0, 32'd0, OP_ADD);
        for (int k = 0; k < ML; k++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mul_early_valid cycle=%0d got=%b exp=0", k, rsp_valid); end
            checks++; if ({alu_a, alu_b, alu_op} !== {32'd15, 32'd7, OP_MUL}) begin errors++; $display("FAIL mul_operands cycle=%0d got=%0d,%0d,%0d exp=15,7,%0d", k, alu_a, alu_b, alu_op, OP_MUL); end
            @(negedge clk);
        end
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mul_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_result !== 32'd105) begin errors++; $display("FAIL mul_result got=%0d exp=105", rsp_result); end
        checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL mul_id got=%0d exp=1", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int exp_g;
        int grants;
        int resps;
        int id_q[$];
        exp_g = 0; grants = 0; resps = 0;
        set_req(0, 1'b1, 32'd100, 32'd100, OP_SUB);
        set_req(1, 1'b1, 32'hAAAAAAAA, 32'h55555555, OP_XOR);
        for (int cyc = 0; cyc < 40 && resps < 4; cyc++) begin
            if (grants >= 4) req_valid = '0;
            #1;
            if (req_ready !== 2'b00) begin
                checks++; if (req_ready !== (2'b01 << exp_g)) begin errors++; $display("FAIL fair_grant n=%0d got=%b exp=%b", grants, req_ready, 2'b01 << exp_g); end
                id_q.push_back(exp_g);
                exp_g = 1 - exp_g;
                grants++;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (id_q.size() == 0) begin
                    errors++; $display("FAIL fair_unexpected_rsp got=1 exp=0");
                end else begin
                    int id;
                    id = id_q.pop_front();
                    if (rsp_id !== IW'(id)) begin errors++; $display("FAIL fair_id got=%0d exp=%0d", rsp_id, id); end
                    if (id == 0 && {rsp_result, rsp_zero, rsp_neg} !== {32'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL fair_sub got=%0h z=%b n=%b exp=0 z=1 n=0", rsp_result, rsp_zero, rsp_neg); end
                    if (id == 1 && {rsp_result, rsp_zero, rsp_neg} !== {32'hFFFFFFFF, 1'b0, 1'b1}) begin errors++; $display("FAIL fair_xor got=%0h z=%b n=%b exp=ffffffff z=0 n=1", rsp_result, rsp_zero, rsp_neg); end
                end
                resps++;
            end
            @(negedge clk);
        end
        checks++; if (resps != 4) begin errors++; $display("FAIL fair_timeout got=%0d exp=4", resps); end
        req_valid = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h1234, 32'h1, OP_ADD);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, OP_ADD);
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_wait_valid got=0 exp=1"); end
        set_req(1, 1'b1, 32'd9, 32'd4, OP_SUB);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h1235}) begin errors++; $display("FAIL bp_frozen cycle=%0d got=%b,%0d,%0h exp=1,0,1235", k, rsp_valid, rsp_id, rsp_result); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_accept cycle=%0d got=%b exp=00", k, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if ({rsp_valid, req_ready} !== 3'b110) begin errors++; $display("FAIL bp_release got=%b exp=110", {rsp_valid, req_ready}); end
        @(negedge clk);
        set_req(1, 1'b0, 32'd0, 32'd0, OP_ADD);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_b2b_exec got=%b exp=0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd5}) begin errors++; $display("FAIL bp_b2b_rsp got=%b,%0d,%0h exp=1,1,5", rsp_valid, rsp_id, rsp_result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        bit stray;
        stray = 1'b0;
        set_req(0, 1'b1, 32'd6, 32'd7, OP_MUL);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, OP_ADD);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if ({req_ready, rsp_valid, busy, rsp_zero, rsp_neg, rsp_ovf} !== '0) begin errors++; $display("FAIL midrst_ctrl got=%b exp=0", {req_ready, rsp_valid, busy, rsp_zero, rsp_neg, rsp_ovf}); end
        checks++; if ({rsp_id, rsp_result, alu_a, alu_b, alu_op} !== '0) begin errors++; $display("FAIL midrst_data got=%0h,%0h,%0h,%0h,%0h exp=0", rsp_id, rsp_result, alu_a, alu_b, alu_op); end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid !== 1'b0) stray = 1'b1;
            @(negedge clk);
        end
        checks++; if (stray) begin errors++; $display("FAIL midrst_stray_rsp got=1 exp=0"); end
        set_req(0, 1'b1, 32'd1, 32'd1, OP_ADD);
        set_req(1, 1'b1, 32'd2, 32'd2, OP_ADD);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_next_grant got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random();
        bit            m_busy;
        int            m_ready_at;
        int            m_last;
        int            m_id;
        logic [DW-1:0] m_a, m_b, m_res;
        logic [OW-1:0] m_op;
        logic [2:0]    m_flags;
        bit            redraw[NR];
        int            wait_cnt[NR];
        int            issued;
        int            cyc;
        m_busy = 1'b0; m_ready_at = 0; m_last = NR - 1; m_id = 0;
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_flags = '0;
        issued = 0; cyc = 0;
        for (int r = 0; r < NR; r++) begin redraw[r] = 1'b0; wait_cnt[r] = 0; end
        rst_n = 1'b0; req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        while (issued < 1000 && cyc < 20000) begin
            bit exp_rv, window, found;
            int g;
            logic [NR-1:0] exp_ready;
            for (int r = 0; r < NR; r++) begin
                if (redraw[r] || !req_valid[r]) begin
                    redraw[r] = 1'b0;
                    if ($urandom_range(0, 2) != 0)
                        set_req(r, 1'b1, ($urandom_range(0, 1) != 0) ? $urandom : DW'($urandom_range(0, 20)),
                                $urandom, OW'($urandom_range(0, 11)));
                    else
                        set_req(r, 1'b0, '0, '0, '0);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = m_busy && (cyc >= m_ready_at);
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
            if (exp_rv) begin
                checks++; if ({rsp_id, rsp_result} !== {IW'(m_id), m_res}) begin errors++; $display("FAIL rnd_rsp cyc=%0d got=%0d,%0h exp=%0d,%0h", cyc, rsp_id, rsp_result, m_id, m_res); end
                checks++; if ({rsp_zero, rsp_neg, rsp_ovf} !== m_flags) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {rsp_zero, rsp_neg, rsp_ovf}, m_flags); end
            end
            if (m_busy) begin
                checks++; if ({alu_a, alu_b, alu_op} !== {m_a, m_b, m_op}) begin errors++; $display("FAIL rnd_alu_hold cyc=%0d got=%0h,%0h,%0d exp=%0h,%0h,%0d", cyc, alu_a, alu_b, alu_op, m_a, m_b, m_op); end
            end
            window = !m_busy || (exp_rv && rsp_ready);
            found = 1'b0; g = 0;
            for (int i = 1; i <= NR; i++) begin
                int c;
                c = (m_last + i) % NR;
                if (!found && req_valid[c]) begin found = 1'b1; g = c; end
            end
            exp_ready = (window && found) ? NR'(1) << g : '0;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            if (exp_rv && rsp_ready) m_busy = 1'b0;
            if (window && found) begin
                for (int r = 0; r < NR; r++) begin
                    if (r == g) wait_cnt[r] = 0;
                    else if (req_valid[r]) begin
                        wait_cnt[r]++;
                        checks++; if (wait_cnt[r] > NR - 1) begin errors++; $display("FAIL rnd_starve req=%0d got=%0d exp<=%0d", r, wait_cnt[r], NR - 1); end
                    end
                end
                m_a  = req_a[g*DW +: DW];
                m_b  = req_b[g*DW +: DW];
                m_op = req_op[g*OW +: OW];
                m_res = ref_alu(m_op, m_a, m_b);
                m_flags = {m_res == '0, m_res[DW-1], ref_ovf(m_op, m_a, m_b)};
                m_ready_at = cyc + ((m_op == OP_MUL) ? 1 + ML : 2);
                m_busy = 1'b1; m_id = g; m_last = g; redraw[g] = 1'b1;
                issued++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (issued < 1000) begin errors++; $display("FAIL rnd_timeout got=%0d exp=1000", issued); end
        req_valid = '0; rsp_ready = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_post_reset();
        test_mul();
        test_fairness();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
